// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: two-requester round-robin front end sharing one serial signed shift-add multiplier
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-low reset
//   req_valid/req_ready - per-requester handshake (bit 0 = requester 0, bit 1 = requester 1)
//   req_a0/req_b0       - signed operands of requester 0
//   req_a1/req_b1       - signed operands of requester 1
//   resp_valid/ready    - shared response handshake
//   resp_result         - signed 2*WIDTH product
//   resp_overflow       - product does not fit in signed WIDTH bits
//   resp_id             - requester that owns the response
//   busy                - an operation is in CALC or DONE
// Macro MUL_SHARE_ARBITER_FAST_ZERO_EN: a zero operand skips CALC and answers on the accepting edge.
module mul_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic signed [WIDTH-1:0]   req_a0,
  input  logic signed [WIDTH-1:0]   req_b0,
  input  logic signed [WIDTH-1:0]   req_a1,
  input  logic signed [WIDTH-1:0]   req_b1,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic signed [2*WIDTH-1:0] resp_result,
  output logic                      resp_overflow,
  output logic                      resp_id,
  output logic                      busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_last, r_sign, r_id;
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [1:0] w_grant;
  logic w_accept, w_sel, w_zero, w_last_bit, w_ovf;
  logic [WIDTH-1:0] w_a, w_b, w_ma, w_mb;
  logic [2*WIDTH-1:0] w_sum, w_res;
  // r_last is the requester served last; on a tie the other one wins
  assign w_grant[0] = req_valid[0] & (~req_valid[1] | r_last);
  assign w_grant[1] = req_valid[1] & (~req_valid[0] | ~r_last);
  assign w_accept = |(req_valid & req_ready);
  assign w_sel = w_grant[1];
  assign w_a = w_sel ? req_a1 : req_a0;
  assign w_b = w_sel ? req_b1 : req_b0;
  // two's-complement negation of the most negative value yields 2^(WIDTH-1) read as unsigned
  assign w_ma = w_a[WIDTH-1] ? -w_a : w_a;
  assign w_mb = w_b[WIDTH-1] ? -w_b : w_b;
`ifdef MUL_SHARE_ARBITER_FAST_ZERO_EN
  assign w_zero = (w_a == '0) | (w_b == '0);
`else
  assign w_zero = 1'b0;
`endif
  assign w_last_bit = r_cnt == CW'(WIDTH - 1);
  assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_res = r_sign ? -w_sum : w_sum;
  assign w_ovf = ~((&w_res[2*WIDTH-1:WIDTH-1]) | ~(|w_res[2*WIDTH-1:WIDTH-1]));
  always_ff @(posedge clk)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_accept ? (w_zero ? DONE : CALC) : IDLE;
      CALC:    w_next = w_last_bit ? DONE : CALC;
      DONE:    w_next = resp_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    resp_valid = r_state == DONE;
    busy = r_state != IDLE;
    req_ready = (r_state == IDLE && reset) ? w_grant : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
      r_last <= 1'b1;
      r_sign <= 1'b0;
      r_id <= 1'b0;
      r_acc <= '0;
      r_mcand <= '0;
      r_mplier <= '0;
      resp_result <= '0;
      resp_overflow <= 1'b0;
      resp_id <= 1'b0;
    end else if (r_state == IDLE && w_accept) begin
      r_last <= w_sel;
      r_id <= w_sel;
      r_sign <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
      r_acc <= '0;
      r_mcand <= {{WIDTH{1'b0}}, w_ma};
      r_mplier <= w_mb;
      r_cnt <= '0;
      if (w_zero) begin
        resp_result <= '0;
        resp_overflow <= 1'b0;
        resp_id <= w_sel;
      end
    end else if (r_state == CALC) begin
      r_acc <= w_sum;
      r_mcand <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt <= r_cnt + 1'b1;
      if (w_last_bit) begin
        resp_result <= w_res;
        resp_overflow <= w_ovf;
        resp_id <= r_id;
      end
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic signed [31:0] req_a0 = 0, req_b0 = 0, req_a1 = 0, req_b1 = 0;
  logic resp_valid;
  logic resp_ready = 1'b0;
  logic signed [63:0] resp_result;
  logic resp_overflow, resp_id, busy;
  int checks = 0;
  int errors = 0;
`ifdef MUL_SHARE_ARBITER_FAST_ZERO_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 32;
`endif
  always #5 clk = ~clk;
  mul_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_overflow(resp_overflow), .resp_id(resp_id), .busy(busy)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // lat = edges after the accepting edge until resp_valid is seen
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask
  task automatic release_resp;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask
  task automatic issue(input logic id, input logic signed [31:0] a, input logic signed [31:0] b);
    if (id) begin
      req_a1 = a; req_b1 = b; req_valid = 2'b10;
    end else begin
      req_a0 = a; req_b0 = b; req_valid = 2'b01;
    end
    step();
    req_valid = 2'b00;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    req_valid = 2'b11;
    step();
    step();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    checks++; if ({resp_valid, busy, resp_overflow, resp_id} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {resp_valid, busy, resp_overflow, resp_id}); end
    checks++; if (resp_result !== 64'd0) begin errors++; $display("FAIL reset_result got %0h exp 0", resp_result); end
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_pointer got %b exp 01", req_ready); end
    req_valid = 2'b00;
  endtask
  task automatic test_basic;
    int lat;
    issue(1'b0, 5, -7);
    wait_resp(lat);
    checks++; if (lat !== 32) begin errors++; $display("FAIL basic_latency got %0d exp 32", lat); end
    checks++; if (resp_result !== -64'sd35) begin errors++; $display("FAIL basic_result got %0d exp -35", resp_result); end
    checks++; if ({resp_overflow, resp_id} !== 2'b00) begin errors++; $display("FAIL basic_ovf_id got %b exp 00", {resp_overflow, resp_id}); end
    release_resp();
  endtask
  task automatic test_overflow;
    int lat;
    issue(1'b1, 32'sh7FFFFFFF, 2);
    wait_resp(lat);
    checks++; if ({resp_overflow, resp_result} !== {1'b1, 64'h00000000FFFFFFFE}) begin errors++; $display("FAIL ovf_max got %b/%h exp 1/00000000fffffffe", resp_overflow, resp_result); end
    release_resp();
    issue(1'b0, 32'sh80000000, 32'sh80000000);
    wait_resp(lat);
    checks++; if ({resp_overflow, resp_result} !== {1'b1, 64'h4000000000000000}) begin errors++; $display("FAIL ovf_minmin got %b/%h exp 1/4000000000000000", resp_overflow, resp_result); end
    release_resp();
    issue(1'b1, -1, -7);
    wait_resp(lat);
    checks++; if ({resp_overflow, resp_id, resp_result} !== {2'b01, 64'd7}) begin errors++; $display("FAIL ovf_negneg got %b/%b/%0d exp 0/1/7", resp_overflow, resp_id, resp_result); end
    release_resp();
  endtask
  task automatic test_backpressure;
    int lat;
    issue(1'b0, 6, 7);
    req_a1 = -3; req_b1 = 4; req_valid = 2'b10;
    wait_resp(lat);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({resp_valid, busy, req_ready} !== 4'b1100 || resp_result !== 64'sd42) begin
        errors++;
        $display("FAIL hold_%0d got v%b b%b rdy%b r%0d exp v1 b1 rdy00 r42", i, resp_valid, busy, req_ready, resp_result);
      end
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %b exp 0", resp_valid); end
    step();
    req_valid = 2'b00;
    wait_resp(lat);
    checks++; if ({resp_id, resp_result} !== {1'b1, -64'sd12}) begin errors++; $display("FAIL hold_waiter got %b/%0d exp 1/-12", resp_id, resp_result); end
    release_resp();
  endtask
  task automatic test_zero;
    int lat;
    issue(1'b1, 11, 0);
    wait_resp(lat);
    checks++; if (lat !== ZLAT) begin errors++; $display("FAIL zero_latency got %0d exp %0d", lat, ZLAT); end
    checks++; if ({resp_overflow, resp_result} !== 65'd0) begin errors++; $display("FAIL zero_result got %b/%0d exp 0/0", resp_overflow, resp_result); end
    release_resp();
  endtask
  task automatic test_reset_abort;
    int lat;
    logic seen;
    issue(1'b0, -9, 5);
    repeat (15) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++; if ({busy, resp_valid} !== 2'b00 || resp_result !== 64'd0) begin errors++; $display("FAIL abort_state got b%b v%b r%0d exp 0 0 0", busy, resp_valid, resp_result); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | resp_valid;
      step();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_noresp got %b exp 0", seen); end
    issue(1'b1, 10, 1);
    wait_resp(lat);
    checks++; if (lat !== 32 || resp_result !== 64'sd10) begin errors++; $display("FAIL abort_next got lat%0d r%0d exp lat32 r10", lat, resp_result); end
    release_resp();
  endtask
  task automatic test_round_robin;
    int lat;
    req_a0 = 2; req_b0 = 3; req_a1 = -12; req_b1 = -4;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_first_ready got %b exp 01", req_ready); end
    step();
    req_a0 = 3; req_b0 = 3;
    wait_resp(lat);
    checks++; if ({resp_id, resp_result} !== {1'b0, 64'sd6}) begin errors++; $display("FAIL rr_first got %b/%0d exp 0/6", resp_id, resp_result); end
    release_resp();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_second_ready got %b exp 10", req_ready); end
    step();
    wait_resp(lat);
    checks++; if ({resp_id, resp_result} !== {1'b1, 64'sd48}) begin errors++; $display("FAIL rr_second got %b/%0d exp 1/48", resp_id, resp_result); end
    release_resp();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_third_ready got %b exp 01", req_ready); end
    step();
    req_valid = 2'b00;
    wait_resp(lat);
    checks++; if ({resp_id, resp_result} !== {1'b0, 64'sd9}) begin errors++; $display("FAIL rr_third got %b/%0d exp 0/9", resp_id, resp_result); end
    release_resp();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_zero();
    test_reset_abort();
    test_round_robin();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
